// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between an instruction-fetch port and a data port.
// MEM normally wins; IF is forced through after STARVE_MAX consecutive MEM grants while it waits.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 19,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              busy
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, GNT_IF, GNT_MEM, ACK_IF, ACK_MEM} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic             r_discard;
  logic             r_if_ack;
  logic             w_grant_mem;
  logic             w_grant_if;
  logic             w_if_keep;

  assign w_grant_mem = mem_req && (!if_req || (r_starve_cnt < CNT_W'(STARVE_MAX)));
  assign w_grant_if  = if_req && !w_grant_mem;
  assign w_if_keep   = !(r_discard || flush);

  // A flush landing in the ack cycle itself can only be honoured by masking the registered pulse.
  assign if_ack = r_if_ack && !flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      r_if_ack     <= 1'b0;
      if_rdata     <= '0;
      mem_ack      <= 1'b0;
      mem_rdata    <= '0;
      busy         <= 1'b0;
      r_starve_cnt <= '0;
      r_discard    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_mem) begin
            r_state   <= GNT_MEM;
            ram_en    <= 1'b1;
            ram_we    <= mem_we;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            busy      <= 1'b1;
            // A MEM grant with IF waiting implies the count is below its ceiling, so no overflow.
            if (if_req) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
          end else if (w_grant_if) begin
            r_state      <= GNT_IF;
            ram_en       <= 1'b1;
            ram_we       <= 1'b0;
            ram_addr     <= if_addr;
            ram_wdata    <= '0;
            busy         <= 1'b1;
            r_starve_cnt <= '0;
          end
        end
        GNT_IF: begin
          if (flush) r_discard <= 1'b1;
          if (ram_ready) begin
            r_state  <= ACK_IF;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            r_if_ack <= w_if_keep;
            if (w_if_keep) if_rdata <= ram_rdata;
          end
        end
        GNT_MEM: begin
          if (ram_ready) begin
            r_state <= ACK_MEM;
            ram_en  <= 1'b0;
            ram_we  <= 1'b0;
            mem_ack <= 1'b1;
            if (!ram_we) mem_rdata <= ram_rdata;
          end
        end
        ACK_IF: begin
          r_state   <= IDLE;
          r_if_ack  <= 1'b0;
          r_discard <= 1'b0;
          busy      <= 1'b0;
        end
        ACK_MEM: begin
          r_state <= IDLE;
          mem_ack <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-phase reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 19;
  localparam int STARVE_MAX = 3;
  localparam int PH_IDLE    = 0;
  localparam int PH_GRANT   = 1;
  localparam int PH_ACK     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              flush;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .flush(flush),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: which requester owns the RAM, which phase of its access it is in,
  // and the data registers the requesters can see.
  int                m_phase = PH_IDLE;
  bit                m_for_mem = 1'b0;
  bit                m_is_write = 1'b0;
  int                m_starve = 0;
  bit                m_discard = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_if_rdata = '0;
  logic [DATA_W-1:0] m_mem_rdata = '0;

  bit last_if_ack, last_mem_ack, last_flush_if, prev_ram_en;
  bit grant_q[$];

  task automatic model_edge();
    if (!reset) begin
      m_phase = PH_IDLE; m_for_mem = 0; m_is_write = 0; m_starve = 0; m_discard = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
    end else if (m_phase == PH_IDLE) begin
      if (mem_req && (!if_req || m_starve < STARVE_MAX)) begin
        m_phase = PH_GRANT; m_for_mem = 1; m_is_write = mem_we;
        m_addr = mem_addr; m_wdata = mem_wdata;
        if (if_req && m_starve < STARVE_MAX) m_starve++;
      end else if (if_req) begin
        m_phase = PH_GRANT; m_for_mem = 0; m_is_write = 0;
        m_addr = if_addr; m_wdata = '0; m_starve = 0;
      end
    end else if (m_phase == PH_GRANT) begin
      if (!m_for_mem && flush) m_discard = 1;
      if (ram_ready) begin
        m_phase = PH_ACK;
        if (m_for_mem && !m_is_write) m_mem_rdata = ram_rdata;
        if (!m_for_mem && !m_discard) m_if_rdata = ram_rdata;
      end
    end else begin
      m_phase = PH_IDLE;
      m_discard = 0;
    end
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic cycle();
    bit e_en, e_we, e_if_ack, e_mem_ack;
    e_en      = (m_phase == PH_GRANT);
    e_we      = e_en && m_for_mem && m_is_write;
    e_if_ack  = (m_phase == PH_ACK) && !m_for_mem && !m_discard && !flush;
    e_mem_ack = (m_phase == PH_ACK) && m_for_mem;
    check_eq("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    check_eq("ram_en", 32'(ram_en), 32'(e_en));
    check_eq("ram_we", 32'(ram_we), 32'(e_we));
    check_eq("ram_addr", 32'(ram_addr), 32'(m_addr));
    check_eq("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
    check_eq("if_ack", 32'(if_ack), 32'(e_if_ack));
    check_eq("if_rdata", 32'(if_rdata), 32'(m_if_rdata));
    check_eq("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
    check_eq("mem_rdata", 32'(mem_rdata), 32'(m_mem_rdata));
    if (ram_en && !prev_ram_en) grant_q.push_back(ram_we);
    prev_ram_en   = ram_en;
    last_if_ack   = e_if_ack;
    last_mem_ack  = e_mem_ack;
    last_flush_if = flush && if_req;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    flush = 0; ram_rdata = '0; ram_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ram_ready = 1; mem_req = 1; if_req = 1;
    reset = 0;
    #1;
    cycle();
    idle_inputs();
    reset = 1;
  endtask

  int en_cnt, ack_cnt;
  bit exp_grants[5];

  initial begin
    idle_inputs();
    reset = 0;
    model_edge();
    @(posedge clk);
    #1;
    do_reset();
    #1;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_ram_en", 32'(ram_en), 32'd0);

    // Zero-wait fetch
    if_req = 1; if_addr = 12'h010; ram_ready = 1; ram_rdata = 19'h1ABCD;
    #1; cycle();
    #1;
    check_eq("fetch_en_k1", 32'(ram_en), 32'd1);
    check_eq("fetch_addr_k1", 32'(ram_addr), 32'h010);
    cycle();
    if_req = 0;
    #1;
    check_eq("fetch_ack_k2", 32'(if_ack), 32'd1);
    check_eq("fetch_data_k2", 32'(if_rdata), 32'h1ABCD);
    cycle();

    // Conflict: MEM writes win three times, then IF, then MEM again
    do_reset();
    grant_q.delete();
    if_req = 1; if_addr = 12'h100; mem_req = 1; mem_we = 1; mem_addr = 12'h020;
    mem_wdata = 19'h00055; ram_ready = 1; ram_rdata = 19'h7FFFF;
    for (int i = 0; i < 18; i++) begin
      #1; cycle();
    end
    exp_grants[0] = 1; exp_grants[1] = 1; exp_grants[2] = 1; exp_grants[3] = 0; exp_grants[4] = 1;
    check_eq("conflict_grants", 32'(grant_q.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < grant_q.size(); i++)
      check_eq($sformatf("conflict_grant%0d_is_mem", i), 32'(grant_q[i]), 32'(exp_grants[i]));

    // Wait states on a MEM read
    do_reset();
    en_cnt = 0; ack_cnt = 0;
    mem_we = 0; mem_addr = 12'h0FF; ram_rdata = 19'h2468A;
    for (int i = 0; i < 9; i++) begin
      ram_ready = (i == 5);
      mem_req = (i < 6);
      #1;
      if (ram_en) begin
        en_cnt++;
        check_eq("wait_addr_stable", 32'(ram_addr), 32'h0FF);
      end
      if (mem_ack) ack_cnt++;
      cycle();
    end
    check_eq("wait_en_cycles", 32'(en_cnt), 32'd5);
    check_eq("wait_ack_count", 32'(ack_cnt), 32'd1);
    check_eq("wait_rdata", 32'(mem_rdata), 32'h2468A);

    // Flush during GNT_IF: read completes, no ack, data unchanged; next fetch is normal
    do_reset();
    en_cnt = 0; ack_cnt = 0;
    if_addr = 12'h033; ram_rdata = 19'h5A5A5;
    for (int i = 0; i < 7; i++) begin
      if_req = (i < 2);
      flush = (i == 1);
      ram_ready = (i == 3);
      #1;
      if (ram_en) en_cnt++;
      if (if_ack) ack_cnt++;
      cycle();
    end
    flush = 0;
    check_eq("flush_en_cycles", 32'(en_cnt), 32'd3);
    check_eq("flush_no_ack", 32'(ack_cnt), 32'd0);
    check_eq("flush_rdata_kept", 32'(if_rdata), 32'd0);
    if_req = 1; if_addr = 12'h044; ram_ready = 1; ram_rdata = 19'h0BEEF;
    #1; cycle();
    #1; cycle();
    if_req = 0;
    #1;
    check_eq("after_flush_ack", 32'(if_ack), 32'd1);
    check_eq("after_flush_data", 32'(if_rdata), 32'h0BEEF);
    cycle();

    // Flush in the ack cycle masks that ack only
    if_req = 1; if_addr = 12'h055; ram_ready = 1; ram_rdata = 19'h0F0F0;
    #1; cycle();
    #1; cycle();
    if_req = 0; flush = 1;
    #1;
    check_eq("ackflush_no_ack", 32'(if_ack), 32'd0);
    check_eq("ackflush_data", 32'(if_rdata), 32'h0F0F0);
    cycle();
    flush = 0;

    // Reset in GNT_MEM abandons the access
    do_reset();
    mem_req = 1; mem_we = 1; mem_addr = 12'h0AA; mem_wdata = 19'h12345; ram_ready = 0;
    #1; cycle();
    #1;
    check_eq("rst_mid_en", 32'(ram_en), 32'd1);
    reset = 0; ram_ready = 1;
    cycle();
    reset = 1; mem_req = 0; ram_ready = 0;
    #1;
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_en_after", 32'(ram_en), 32'd0);
    check_eq("rst_mid_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_mid_wdata", 32'(ram_wdata), 32'd0);
    check_eq("rst_mid_ack", 32'(mem_ack), 32'd0);
    cycle();
    #1;
    check_eq("rst_mid_ack_later", 32'(mem_ack), 32'd0);
    cycle();

    // Randomized traffic obeying the requester protocol
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      if (if_req) begin
        if (last_if_ack || last_flush_if) if_req = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        if_req = 1; if_addr = ADDR_W'($urandom());
      end
      if (mem_req) begin
        if (last_mem_ack) mem_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        mem_req = 1; mem_we = 1'($urandom_range(0, 1));
        mem_addr = ADDR_W'($urandom()); mem_wdata = DATA_W'($urandom());
      end
      flush     = ($urandom_range(0, 5) == 0);
      ram_ready = ($urandom_range(0, 2) != 0);
      ram_rdata = DATA_W'($urandom());
      reset     = ($urandom_range(0, 80) != 0);
      #1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- ADDR_W, 12, memory address width.
- DATA_W, 19, memory word width (instruction width).
- STARVE_MAX, 3, consecutive MEM grants tolerated while IF waits.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge.
- reset, in, 1, synchronous, active-low reset.
- if_req, in, 1, fetch read request, held until if_ack or flush.
- if_addr, in, ADDR_W, fetch address, stable while if_req=1.
- if_ack, out, 1, one-cycle fetch completion pulse.
- if_rdata, out, DATA_W, fetched word, valid when if_ack=1.
- mem_req, in, 1, data-stage request, held until mem_ack.
- mem_we, in, 1, 1=write, 0=read.
- mem_addr, in, ADDR_W, data address.
- mem_wdata, in, DATA_W, write data.
- mem_ack, out, 1, one-cycle data completion pulse.
- mem_rdata, out, DATA_W, read word, valid when mem_ack=1 and read.
- flush, in, 1, branch taken; cancel the pending fetch result.
- ram_en, out, 1, memory access strobe.
- ram_we, out, 1, memory write enable.
- ram_addr, out, ADDR_W, memory address.
- ram_wdata, out, DATA_W, memory write data.
- ram_rdata, in, DATA_W, memory read data, valid with ram_ready.
- ram_ready, in, 1, memory completes the current access this cycle.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 FSM states SHALL be IDLE, GNT_IF, GNT_MEM, ACK_IF, ACK_MEM; all outputs registered.
REQ-004 IDLE SHALL arbitrate each cycle:
- mem_req=1 and (if_req=0 or starve_cnt<STARVE_MAX) -> GNT_MEM.
- else if_req=1 -> GNT_IF.
- else stay in IDLE.
REQ-005 On entering GNT_x, ram_addr/ram_wdata/ram_we SHALL load from requester x; ram_en=1 throughout GNT_x; ram_we=0 always for IF.
REQ-006 In GNT_x with ram_ready=1, next state SHALL be ACK_x; ram_en/ram_we drop; x_rdata captures ram_rdata.
REQ-007 GNT_x with ram_ready=0 SHALL hold the state and all ram_* outputs unchanged (unbounded wait).
REQ-008 ACK_x SHALL assert x_ack for exactly one cycle, then go to IDLE; no back-to-back grant from ACK.
REQ-009 Zero-wait latency: req sampled high in IDLE at cycle k -> ram_en at k+1 -> x_ack at k+2.
REQ-010 starve_cnt (saturating, 0..STARVE_MAX) SHALL increment on each MEM grant with if_req=1, clear on each IF grant, and hold otherwise.
REQ-011 flush=1 in GNT_IF SHALL set a discard flag; the RAM read still completes; ACK_IF then keeps if_ack=0 and if_rdata unchanged.
REQ-012 flush=1 in ACK_IF SHALL suppress that cycle's if_ack.
REQ-013 flush SHALL have no effect in IDLE or in MEM states; MEM accesses are never aborted.
REQ-014 The discard flag SHALL clear on leaving ACK_IF.
REQ-015 Simultaneous if_req and mem_req SHALL follow REQ-004 priority; the losing request stays pending with no ack.
REQ-016 mem_rdata SHALL be unchanged by a write access.

Reset
REQ-017 reset=0 at a rising edge SHALL force, regardless of other inputs:
- state IDLE; ram_en, ram_we, if_ack, mem_ack, busy = 0.
- ram_addr, ram_wdata, if_rdata, mem_rdata = 0.
- starve_cnt and discard flag = 0.
REQ-018 Reset mid-transaction SHALL abandon the access with no ack; ram_ready in that cycle is ignored.

Verification
REQ-019 Fetch: if_req=1, if_addr=0x010, ram_ready tied 1, ram_rdata=0x1ABCD -> ram_en at k+1; if_ack=1 with if_rdata=0x1ABCD at k+2.
REQ-020 Conflict: if_req and mem_req both held, writes to 0x020, wdata=0x00055, ram_ready=1 -> grants MEM, MEM, MEM, IF (STARVE_MAX=3), then MEM.
REQ-021 Wait states: mem read 0x0FF with ram_ready low 4 cycles -> ram_en high 5 cycles, ram_addr=0x0FF stable, one mem_ack.
REQ-022 Flush: flush pulse during GNT_IF with ram_ready=0 -> RAM read completes; if_ack never asserts; next IF request served normally.
REQ-023 Reset: reset=0 during GNT_MEM -> next cycle all outputs 0, state IDLE, no mem_ack.
